// File: rtl/ex_mdu_pkg.sv
// Shared constants and types for the RV32IM execute stage and its iterative mul/div unit.
package ex_mdu_pkg;

  localparam logic [6:0] INST_TYPE_R_M  = 7'b0110011;
  localparam logic [6:0] INST_TYPE_I    = 7'b0010011;
  localparam logic [6:0] INST_TYPE_LUI  = 7'b0110111;
  localparam logic [6:0] INST_TYPE_AUIPC = 7'b0010111;
  localparam logic [6:0] INST_TYPE_JAL  = 7'b1101111;
  localparam logic [6:0] INST_TYPE_JALR = 7'b1100111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } mduState_e;

endpackage

// File: rtl/ex_mdu_stage_iter.sv
// Iterative shift-add multiplier / restoring divider on operand magnitudes, with sign fix-up.
module ex_mdu_iter #(
  parameter int XLEN        = 32,
  parameter int MDU_RADIX_W = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_run,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_opA,
  input  logic [XLEN-1:0] i_opB,
  output logic            o_last,
  output logic [XLEN-1:0] o_result
);
  import ex_mdu_pkg::*;

  localparam int ITERS = XLEN / MDU_RADIX_W;
  localparam int CNT_W = $clog2(ITERS);

  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] w_accNext;
  logic [2*XLEN-1:0] w_full;
  logic [XLEN-1:0]   r_opB;
  logic [XLEN-1:0]   w_absA;
  logic [XLEN-1:0]   w_absB;
  logic [XLEN-1:0]   w_sel;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_isDiv;
  logic              r_negRes;
  logic              r_selHi;
  logic              w_isDiv;
  logic              w_signA;
  logic              w_signB;
  logic              w_negA;
  logic              w_negB;
  logic              w_negRes;
  logic              w_selHi;

  // acc holds {remainder, quotient} for divide and {partial product, multiplier} for multiply.
  function automatic logic [2*XLEN-1:0] mduStep(input logic [2*XLEN-1:0] acc,
                                                input logic [XLEN-1:0]   b,
                                                input logic              isDiv);
    logic [XLEN:0] part;
    logic [XLEN:0] diff;
    part = acc[2*XLEN-1:XLEN-1];
    diff = part - {1'b0, b};
    if (isDiv) begin
      if (!diff[XLEN]) mduStep = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else             mduStep = {part[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      part    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b} : {(XLEN+1){1'b0}});
      mduStep = {part, acc[XLEN-1:1]};
    end
  endfunction

  always_comb begin
    w_isDiv = i_funct3[2];
    if (w_isDiv) begin
      w_signA = ~i_funct3[0];
      w_signB = ~i_funct3[0];
    end else begin
      w_signA = (i_funct3 != F3_MULHU);
      w_signB = (i_funct3 == F3_MUL) || (i_funct3 == F3_MULH);
    end
    w_negA  = w_signA & i_opA[XLEN-1];
    w_negB  = w_signB & i_opB[XLEN-1];
    w_absA  = w_negA ? -i_opA : i_opA;
    w_absB  = w_negB ? -i_opB : i_opB;
    w_selHi = w_isDiv ? i_funct3[1] : (i_funct3[1:0] != 2'b00);
    // A zero divisor must leave the all-ones quotient un-negated.
    if (w_isDiv) w_negRes = i_funct3[1] ? w_negA : ((w_negA ^ w_negB) & (|i_opB));
    else         w_negRes = w_negA ^ w_negB;
  end

  always_comb begin
    w_accNext = r_acc;
    for (int k = 0; k < MDU_RADIX_W; k++) begin
      w_accNext = mduStep(w_accNext, r_opB, r_isDiv);
    end
  end

  always_comb begin
    w_full = r_negRes ? -w_accNext : w_accNext;
    w_sel  = r_selHi ? w_accNext[2*XLEN-1:XLEN] : w_accNext[XLEN-1:0];
    if (r_isDiv) o_result = r_negRes ? -w_sel : w_sel;
    else         o_result = r_selHi ? w_full[2*XLEN-1:XLEN] : w_full[XLEN-1:0];
    o_last = (r_cnt == CNT_W'(ITERS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc    <= '0;
      r_opB    <= '0;
      r_cnt    <= '0;
      r_isDiv  <= DISABLE;
      r_negRes <= DISABLE;
      r_selHi  <= DISABLE;
    end else if (i_start) begin
      r_acc    <= {{XLEN{1'b0}}, w_absA};
      r_opB    <= w_absB;
      r_cnt    <= '0;
      r_isDiv  <= w_isDiv;
      r_negRes <= w_negRes;
      r_selHi  <= w_selHi;
    end else if (i_run) begin
      r_acc <= w_accNext;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ex_mdu_stage.sv
// Registered RV32IM execute stage: single-cycle ALU plus an FSM sequencing the iterative mul/div unit.
module ex_mdu_stage #(
  parameter int XLEN        = 32,
  parameter int REG_AW      = 5,
  parameter int MDU_RADIX_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic              hold_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  output logic              rd_wr_en_o,
  output logic [REG_AW-1:0] rd_o,
  output logic [XLEN-1:0]   rd_data_o,
  output logic              busy_o
);
  import ex_mdu_pkg::*;

  localparam int SH_W = $clog2(XLEN);

  mduState_e         r_state;
  mduState_e         w_stateNext;
  logic              r_outValid;
  logic              r_rdWrEn;
  logic [REG_AW-1:0] r_rd;
  logic [REG_AW-1:0] r_mduRd;
  logic [XLEN-1:0]   r_rdData;
  logic [XLEN-1:0]   w_opB;
  logic [XLEN-1:0]   w_aluResult;
  logic [XLEN-1:0]   w_mduResult;
  logic [SH_W-1:0]   w_shamt;
  logic              w_aluWrites;
  logic              w_isMdu;
  logic              w_isAlt;
  logic              w_accept;
  logic              w_mduStart;
  logic              w_mduRun;
  logic              w_mduFinish;
  logic              w_last;

  assign w_isMdu     = (opcode_i == INST_TYPE_R_M) && (funct7_i == F7_MULDIV);
  assign w_isAlt     = (funct7_i == F7_ALT);
  assign w_accept    = in_valid_i & in_ready_o & ~flush_i;
  assign w_mduStart  = w_accept & w_isMdu;
  assign w_mduRun    = busy_o & ~hold_i & ~flush_i;
  assign w_mduFinish = w_mduRun & w_last;

  assign out_valid_o = r_outValid;
  assign rd_wr_en_o  = r_rdWrEn;
  assign rd_o        = r_rd;
  assign rd_data_o   = r_rdData;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    if (flush_i) begin
      w_stateNext = ST_IDLE;
    end else if (!hold_i) begin
      case (r_state)
        ST_IDLE:        if (w_mduStart) w_stateNext = funct3_i[2] ? ST_DIV : ST_MUL;
        ST_MUL, ST_DIV: if (w_last) w_stateNext = ST_DONE;
        ST_DONE:        w_stateNext = ST_IDLE;
        default:        w_stateNext = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready_o = (r_state == ST_IDLE) && !hold_i;
    busy_o     = (r_state == ST_MUL) || (r_state == ST_DIV);
  end

  always_comb begin
    w_opB       = (opcode_i == INST_TYPE_R_M) ? rs2_data_i : imm_i;
    w_shamt     = w_opB[SH_W-1:0];
    w_aluResult = '0;
    w_aluWrites = DISABLE;
    case (opcode_i)
      INST_TYPE_R_M, INST_TYPE_I: begin
        w_aluWrites = ENABLE;
        case (funct3_i)
          F3_ADD:  w_aluResult = ((opcode_i == INST_TYPE_R_M) && w_isAlt) ?
                                 rs1_data_i - w_opB : rs1_data_i + w_opB;
          F3_SLL:  w_aluResult = rs1_data_i << w_shamt;
          F3_SLT:  w_aluResult = {{(XLEN-1){1'b0}}, ($signed(rs1_data_i) < $signed(w_opB))};
          F3_SLTU: w_aluResult = {{(XLEN-1){1'b0}}, (rs1_data_i < w_opB)};
          F3_XOR:  w_aluResult = rs1_data_i ^ w_opB;
          F3_SR:   w_aluResult = w_isAlt ? $unsigned($signed(rs1_data_i) >>> w_shamt) :
                                 rs1_data_i >> w_shamt;
          F3_OR:   w_aluResult = rs1_data_i | w_opB;
          F3_AND:  w_aluResult = rs1_data_i & w_opB;
          default: w_aluResult = '0;
        endcase
      end
      INST_TYPE_LUI:   begin w_aluWrites = ENABLE; w_aluResult = imm_i; end
      INST_TYPE_AUIPC: begin w_aluWrites = ENABLE; w_aluResult = pc_i + imm_i; end
      INST_TYPE_JAL,
      INST_TYPE_JALR:  begin w_aluWrites = ENABLE; w_aluResult = pc_i + XLEN'(4); end
      default:         ;
    endcase
  end

  // Output regs freeze under hold so a pending pulse survives until write-back can take it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_outValid <= DISABLE;
      r_rdWrEn   <= DISABLE;
      r_rd       <= '0;
      r_rdData   <= '0;
      r_mduRd    <= '0;
    end else if (flush_i) begin
      r_outValid <= DISABLE;
      r_rdWrEn   <= DISABLE;
    end else if (!hold_i) begin
      r_outValid <= DISABLE;
      r_rdWrEn   <= DISABLE;
      if (w_accept && !w_isMdu) begin
        r_outValid <= ENABLE;
        r_rd       <= rd_i;
        r_rdData   <= w_aluResult;
        r_rdWrEn   <= w_aluWrites && (rd_i != '0);
      end else if (w_mduFinish) begin
        r_outValid <= ENABLE;
        r_rd       <= r_mduRd;
        r_rdData   <= w_mduResult;
        r_rdWrEn   <= (r_mduRd != '0);
      end
      if (w_mduStart) r_mduRd <= rd_i;
    end
  end

  ex_mdu_iter #(
    .XLEN        (XLEN),
    .MDU_RADIX_W (MDU_RADIX_W)
  ) u_mduIter (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_mduStart),
    .i_run    (w_mduRun),
    .i_funct3 (funct3_i),
    .i_opA    (rs1_data_i),
    .i_opB    (rs2_data_i),
    .o_last   (w_last),
    .o_result (w_mduResult)
  );

endmodule

// File: tb/tb_ex_mdu_stage.sv
// Directed-vector bench for ex_mdu_stage: ALU ops, mul/div corner cases, hold, flush and reset.
module tb_ex_mdu_stage;
  import ex_mdu_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [6:0]  funct7_i;
  logic [4:0]  rd_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [31:0] imm_i;
  logic [31:0] pc_i;
  logic        hold_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        rd_wr_en_o;
  logic [4:0]  rd_o;
  logic [31:0] rd_data_o;
  logic        busy_o;

  int testCount = 0;
  int failCount = 0;

  ex_mdu_stage #(.XLEN(32), .REG_AW(5), .MDU_RADIX_W(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .opcode_i    (opcode_i),
    .funct3_i    (funct3_i),
    .funct7_i    (funct7_i),
    .rd_i        (rd_i),
    .rs1_data_i  (rs1_data_i),
    .rs2_data_i  (rs2_data_i),
    .imm_i       (imm_i),
    .pc_i        (pc_i),
    .hold_i      (hold_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .rd_wr_en_o  (rd_wr_en_o),
    .rd_o        (rd_o),
    .rd_data_o   (rd_data_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic [31:0] pc);
    in_valid_i = 1'b1;
    opcode_i   = op;
    funct3_i   = f3;
    funct7_i   = f7;
    rd_i       = rd;
    rs1_data_i = a;
    rs2_data_i = b;
    imm_i      = imm;
    pc_i       = pc;
  endtask

  task automatic runAlu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                        input logic [31:0] expData, input logic expWr);
    applyStimulus(op, f3, f7, rd, a, b, imm, pc);
    tick();
    in_valid_i = 1'b0;
    checkOutput({tag, ".valid"}, 32'(out_valid_o), 32'd1);
    checkOutput({tag, ".rd"}, 32'(rd_o), 32'(rd));
    checkOutput({tag, ".data"}, rd_data_o, expData);
    checkOutput({tag, ".wren"}, 32'(rd_wr_en_o), 32'(expWr));
  endtask

  // Operands are scrambled after acceptance: the result must come from the latched copies.
  task automatic runMdu(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b, input int holdAt,
                        input int holdLen, input logic [31:0] expData, input int expLat,
                        input int expBusy);
    int cycles;
    int busyCnt;
    applyStimulus(INST_TYPE_R_M, f3, F7_MULDIV, rd, a, b, 32'h0, 32'h0);
    tick();
    in_valid_i = 1'b0;
    rs1_data_i = $urandom;
    rs2_data_i = $urandom;
    funct3_i   = 3'($urandom_range(0, 7));
    cycles     = 1;
    busyCnt    = 0;
    checkOutput({tag, ".readyLow"}, 32'(in_ready_o), 32'd0);
    while (!out_valid_o && cycles < 80) begin
      if (busy_o) busyCnt++;
      hold_i = (cycles >= holdAt) && (cycles < holdAt + holdLen);
      tick();
      cycles++;
    end
    hold_i = 1'b0;
    checkOutput({tag, ".latency"}, 32'(cycles), 32'(expLat));
    checkOutput({tag, ".busyCycles"}, 32'(busyCnt), 32'(expBusy));
    checkOutput({tag, ".data"}, rd_data_o, expData);
    checkOutput({tag, ".wren"}, 32'(rd_wr_en_o), 32'(rd != 5'd0));
    tick();
    checkOutput({tag, ".pulseEnd"}, 32'(out_valid_o), 32'd0);
  endtask

  task automatic watchNoStray(input string tag, input int nCycles);
    logic sawValid;
    sawValid = 1'b0;
    for (int i = 0; i < nCycles; i++) begin
      tick();
      if (out_valid_o) sawValid = 1'b1;
    end
    checkOutput(tag, 32'(sawValid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid_i = 1'b0;
    opcode_i = 7'h0;
    funct3_i = 3'h0;
    funct7_i = 7'h0;
    rd_i = 5'h0;
    rs1_data_i = 32'h0;
    rs2_data_i = 32'h0;
    imm_i = 32'h0;
    pc_i = 32'h0;
    hold_i = 1'b0;
    flush_i = 1'b0;
    repeat (3) tick();
    checkOutput("reset.valid", 32'(out_valid_o), 32'd0);
    checkOutput("reset.wren", 32'(rd_wr_en_o), 32'd0);
    checkOutput("reset.busy", 32'(busy_o), 32'd0);
    checkOutput("reset.rd", 32'(rd_o), 32'd0);
    checkOutput("reset.data", rd_data_o, 32'd0);
    checkOutput("reset.ready", 32'(in_ready_o), 32'd1);
    rst = 1'b0;
    tick();

    // Back-to-back single-cycle ops.
    runAlu("addi", INST_TYPE_I, F3_ADD, F7_BASE, 5'd5, 32'h10, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0000_000F, 1'b1);
    runAlu("sub", INST_TYPE_R_M, F3_ADD, F7_ALT, 5'd1, 32'd7, 32'd9, 32'h0, 32'h0, 32'hFFFF_FFFE, 1'b1);
    runAlu("sra", INST_TYPE_R_M, F3_SR, F7_ALT, 5'd2, 32'h8000_0000, 32'd4, 32'h0, 32'h0, 32'hF800_0000, 1'b1);
    runAlu("srl", INST_TYPE_R_M, F3_SR, F7_BASE, 5'd2, 32'h8000_0000, 32'd4, 32'h0, 32'h0, 32'h0800_0000, 1'b1);
    runAlu("slt", INST_TYPE_R_M, F3_SLT, F7_BASE, 5'd3, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 32'd1, 1'b1);
    runAlu("sltu", INST_TYPE_R_M, F3_SLTU, F7_BASE, 5'd3, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 32'd0, 1'b1);
    runAlu("slli", INST_TYPE_I, F3_SLL, F7_BASE, 5'd4, 32'd1, 32'h0, 32'd31, 32'h0, 32'h8000_0000, 1'b1);
    runAlu("xori", INST_TYPE_I, F3_XOR, F7_BASE, 5'd4, 32'h0F0F_0F0F, 32'h0, 32'hFFFF_00FF, 32'h0, 32'hF0F0_0FF0, 1'b1);
    runAlu("lui", INST_TYPE_LUI, F3_ADD, F7_BASE, 5'd6, 32'h0, 32'h0, 32'h1234_5000, 32'h0, 32'h1234_5000, 1'b1);
    runAlu("auipc", INST_TYPE_AUIPC, F3_ADD, F7_BASE, 5'd7, 32'h0, 32'h0, 32'h2000, 32'h1000, 32'h3000, 1'b1);
    runAlu("jal", INST_TYPE_JAL, F3_ADD, F7_BASE, 5'd1, 32'h0, 32'h0, 32'h40, 32'h100, 32'h104, 1'b1);
    runAlu("addRd0", INST_TYPE_R_M, F3_ADD, F7_BASE, 5'd0, 32'd3, 32'd4, 32'h0, 32'h0, 32'd7, 1'b0);
    runAlu("branch", 7'b1100011, F3_ADD, F7_BASE, 5'd9, 32'd3, 32'd4, 32'h0, 32'h0, 32'd0, 1'b0);

    // A pending result stays asserted while held, then drops once released.
    runAlu("holdAlu", INST_TYPE_I, F3_ADD, F7_BASE, 5'd8, 32'd20, 32'h0, 32'd22, 32'h0, 32'd42, 1'b1);
    hold_i = 1'b1;
    repeat (3) tick();
    checkOutput("holdAlu.stillValid", 32'(out_valid_o), 32'd1);
    checkOutput("holdAlu.stillData", rd_data_o, 32'd42);
    checkOutput("holdAlu.readyLow", 32'(in_ready_o), 32'd0);
    hold_i = 1'b0;
    tick();
    checkOutput("holdAlu.released", 32'(out_valid_o), 32'd0);

    runMdu("mulh", F3_MULH, 5'd10, 32'h8000_0000, 32'h8000_0000, 1000, 0, 32'h4000_0000, 33, 32);
    runMdu("mul", F3_MUL, 5'd10, 32'd3, 32'hFFFF_FFFB, 1000, 0, 32'hFFFF_FFF1, 33, 32);
    runMdu("mulhu", F3_MULHU, 5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1000, 0, 32'hFFFF_FFFE, 33, 32);
    runMdu("mulhsu", F3_MULHSU, 5'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1000, 0, 32'hFFFF_FFFF, 33, 32);
    runMdu("divBy0", F3_DIV, 5'd11, 32'd7, 32'd0, 1000, 0, 32'hFFFF_FFFF, 33, 32);
    runMdu("remBy0", F3_REM, 5'd11, 32'd7, 32'd0, 1000, 0, 32'd7, 33, 32);
    runMdu("divOvf", F3_DIV, 5'd11, 32'h8000_0000, 32'hFFFF_FFFF, 1000, 0, 32'h8000_0000, 33, 32);
    runMdu("remOvf", F3_REM, 5'd11, 32'h8000_0000, 32'hFFFF_FFFF, 1000, 0, 32'd0, 33, 32);
    runMdu("divNeg", F3_DIV, 5'd12, 32'hFFFF_FFF9, 32'd2, 1000, 0, 32'hFFFF_FFFD, 33, 32);
    runMdu("remNeg", F3_REM, 5'd12, 32'hFFFF_FFF9, 32'd2, 1000, 0, 32'hFFFF_FFFF, 33, 32);
    runMdu("divuHold", F3_DIVU, 5'd13, 32'd100, 32'd7, 10, 5, 32'd14, 38, 37);
    runMdu("remu", F3_REMU, 5'd13, 32'd100, 32'd7, 1000, 0, 32'd2, 33, 32);
    runMdu("mulRd0", F3_MUL, 5'd0, 32'd6, 32'd7, 1000, 0, 32'd42, 33, 32);

    // Flush mid-divide with a competing ADDI in the same cycle.
    applyStimulus(INST_TYPE_R_M, F3_DIV, F7_MULDIV, 5'd14, 32'd100, 32'd7, 32'h0, 32'h0);
    tick();
    in_valid_i = 1'b0;
    repeat (2) tick();
    flush_i = 1'b1;
    applyStimulus(INST_TYPE_I, F3_ADD, F7_BASE, 5'd6, 32'd1, 32'h0, 32'd1, 32'h0);
    tick();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    checkOutput("flush.valid", 32'(out_valid_o), 32'd0);
    checkOutput("flush.busy", 32'(busy_o), 32'd0);
    checkOutput("flush.ready", 32'(in_ready_o), 32'd1);
    runAlu("flushReissue", INST_TYPE_I, F3_ADD, F7_BASE, 5'd6, 32'd1, 32'h0, 32'd1, 32'h0, 32'd2, 1'b1);
    watchNoStray("flush.noStray", 40);

    // Reset in the middle of a multiply.
    applyStimulus(INST_TYPE_R_M, F3_MUL, F7_MULDIV, 5'd15, 32'd9, 32'd9, 32'h0, 32'h0);
    tick();
    in_valid_i = 1'b0;
    repeat (19) tick();
    checkOutput("rstMid.busyBefore", 32'(busy_o), 32'd1);
    rst = 1'b1;
    tick();
    checkOutput("rstMid.valid", 32'(out_valid_o), 32'd0);
    checkOutput("rstMid.wren", 32'(rd_wr_en_o), 32'd0);
    checkOutput("rstMid.busy", 32'(busy_o), 32'd0);
    checkOutput("rstMid.rd", 32'(rd_o), 32'd0);
    checkOutput("rstMid.data", rd_data_o, 32'd0);
    checkOutput("rstMid.ready", 32'(in_ready_o), 32'd1);
    rst = 1'b0;
    watchNoStray("rstMid.noStray", 40);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
